// File: rtl/rgb2raw.sv
// Bayer mosaic encoder: one RGB pixel in, one 10-bit raw sample out, selected by the GR/BG phase at (col,row).
// Optional build macro RGB2RAW_PATTERN_EN adds the pattern_en port and an internal 8-bar colour-bar source.
module rgb2raw #(
  parameter int COLS = 1280,
  parameter int ROWS = 1024
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       data_valid,
  input  logic       sof,
  input  logic [9:0] r_in,
  input  logic [9:0] g_in,
  input  logic [9:0] b_in,
`ifdef RGB2RAW_PATTERN_EN
  input  logic       pattern_en,
`endif
  output logic       data_valid_out,
  output logic [9:0] data_out,
  output logic       line_end,
  output logic       frame_end
);

  localparam logic [10:0] COL_LAST = 11'(COLS - 1);
  localparam logic [10:0] ROW_LAST = 11'(ROWS - 1);

  logic [10:0] col_q, col_d, row_q, row_d;
  logic [10:0] col_cur_s, row_cur_s;
  logic        col_last_s, row_last_s;
  logic [9:0]  pix_r_s, pix_g_s, pix_b_s;
  logic [9:0]  sample_s;

  // A qualified sof forces the current pixel to (0,0) before selection and increment.
  always_comb begin
    col_cur_s  = col_q;
    row_cur_s  = row_q;
    if (sof) begin
      col_cur_s = 11'd0;
      row_cur_s = 11'd0;
    end else begin
      col_cur_s = col_q;
      row_cur_s = row_q;
    end
    col_last_s = (col_cur_s == COL_LAST);
    row_last_s = (row_cur_s == ROW_LAST);
    col_d      = col_q;
    row_d      = row_q;
    if (data_valid) begin
      if (col_last_s) begin
        col_d = 11'd0;
        row_d = row_last_s ? 11'd0 : row_cur_s + 11'd1;
      end else begin
        col_d = col_cur_s + 11'd1;
        row_d = row_cur_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      col_q <= 11'd0;
      row_q <= 11'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

`ifdef RGB2RAW_PATTERN_EN
  // With fewer than 8 columns every bar but the last is empty, so start in bar 7.
  localparam logic [2:0]  BAR_FIRST = (COLS / 8 > 0) ? 3'd0 : 3'd7;
  localparam logic [10:0] BAR_W_M1  = 11'(((COLS / 8 > 0) ? COLS / 8 : 1) - 1);

  logic [2:0]  bar_q, bar_d, bar_cur_s;
  logic [10:0] inbar_q, inbar_d, inbar_cur_s;

  always_comb begin
    bar_cur_s   = sof ? BAR_FIRST : bar_q;
    inbar_cur_s = sof ? 11'd0 : inbar_q;
    bar_d       = bar_q;
    inbar_d     = inbar_q;
    if (data_valid) begin
      if (col_last_s) begin
        bar_d   = BAR_FIRST;
        inbar_d = 11'd0;
      end else if ((bar_cur_s != 3'd7) && (inbar_cur_s == BAR_W_M1)) begin
        bar_d   = bar_cur_s + 3'd1;
        inbar_d = 11'd0;
      end else begin
        bar_d   = bar_cur_s;
        inbar_d = inbar_cur_s + 11'd1;
      end
    end else begin
      bar_d   = bar_q;
      inbar_d = inbar_q;
    end
    if (pattern_en) begin
      pix_r_s = {10{bar_cur_s[2]}};
      pix_g_s = {10{bar_cur_s[1]}};
      pix_b_s = {10{bar_cur_s[0]}};
    end else begin
      pix_r_s = r_in;
      pix_g_s = g_in;
      pix_b_s = b_in;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      bar_q   <= BAR_FIRST;
      inbar_q <= 11'd0;
    end else begin
      bar_q   <= bar_d;
      inbar_q <= inbar_d;
    end
  end
`else
  assign pix_r_s = r_in;
  assign pix_g_s = g_in;
  assign pix_b_s = b_in;
`endif

  // Phase: even row G/R, odd row B/G.
  always_comb begin
    sample_s = pix_g_s;
    case ({row_cur_s[0], col_cur_s[0]})
      2'b00:   sample_s = pix_g_s;
      2'b01:   sample_s = pix_r_s;
      2'b10:   sample_s = pix_b_s;
      2'b11:   sample_s = pix_g_s;
      default: sample_s = pix_g_s;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      data_valid_out <= 1'b0;
      data_out       <= 10'd0;
      line_end       <= 1'b0;
      frame_end      <= 1'b0;
    end else if (data_valid) begin
      data_valid_out <= 1'b1;
      data_out       <= sample_s;
      line_end       <= col_last_s;
      frame_end      <= col_last_s & row_last_s;
    end else begin
      data_valid_out <= 1'b0;
      line_end       <= 1'b0;
      frame_end      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgb2raw.sv
// Directed bench for rgb2raw at COLS=4, ROWS=2; adds a COLS=16 instance for the colour-bar source
// when RGB2RAW_PATTERN_EN is defined.
module tb_rgb2raw;
  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       data_valid = 1'b0;
  logic       sof = 1'b0;
  logic [9:0] r_in = 10'd100;
  logic [9:0] g_in = 10'd200;
  logic [9:0] b_in = 10'd300;
  logic       pattern_en = 1'b0;
  logic       data_valid_out, line_end, frame_end;
  logic [9:0] data_out;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Expected sample stream of one COLS=4/ROWS=2 frame with r/g/b = 100/200/300.
  logic [9:0] frame_d [8] = '{10'd200, 10'd100, 10'd200, 10'd100, 10'd300, 10'd200, 10'd300, 10'd200};
  logic       frame_le[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       frame_fe[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  rgb2raw #(.COLS(4), .ROWS(2)) dut (
    .clk(clk), .aclr(aclr), .data_valid(data_valid), .sof(sof),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
`ifdef RGB2RAW_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .data_valid_out(data_valid_out), .data_out(data_out),
    .line_end(line_end), .frame_end(frame_end)
  );

`ifdef RGB2RAW_PATTERN_EN
  logic       p_dvo, p_le, p_fe;
  logic [9:0] p_data;

  rgb2raw #(.COLS(16), .ROWS(2)) dut_pat (
    .clk(clk), .aclr(aclr), .data_valid(data_valid), .sof(sof),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .pattern_en(pattern_en),
    .data_valid_out(p_dvo), .data_out(p_data), .line_end(p_le), .frame_end(p_fe)
  );
`endif

  task automatic drive(input logic v, input logic s);
    @(negedge clk);
    data_valid = v;
    sof        = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    cmp_cnt++;
    if ({data_valid_out, line_end, frame_end, data_out} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset: got dvo=%b le=%b fe=%b d=%0d want all 0", data_valid_out, line_end, frame_end, data_out);
    end
    @(negedge clk);
    aclr = 1'b1;
  endtask

  task automatic test_frame;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0);
      cmp_cnt++;
      if ({data_valid_out, line_end, frame_end, data_out} !== {1'b1, frame_le[i], frame_fe[i], frame_d[i]}) begin
        err_cnt++;
        $display("FAIL frame[%0d]: got dvo=%b le=%b fe=%b d=%0d want 1 %b %b %0d", i,
                 data_valid_out, line_end, frame_end, data_out, frame_le[i], frame_fe[i], frame_d[i]);
      end
    end
    drive(1'b0, 1'b0);
    cmp_cnt++;
    if ({data_valid_out, line_end, frame_end, data_out} !== {3'b000, 10'd200}) begin
      err_cnt++;
      $display("FAIL frame_idle: got dvo=%b le=%b fe=%b d=%0d want 0 0 0 200", data_valid_out, line_end, frame_end, data_out);
    end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 16; i++) begin
      drive(i % 2 == 0, i == 0);
      cmp_cnt++;
      if (i % 2 == 0) begin
        if ({data_valid_out, line_end, frame_end, data_out} !== {1'b1, frame_le[i/2], frame_fe[i/2], frame_d[i/2]}) begin
          err_cnt++;
          $display("FAIL gaps_valid[%0d]: got dvo=%b le=%b fe=%b d=%0d want 1 %b %b %0d", i,
                   data_valid_out, line_end, frame_end, data_out, frame_le[i/2], frame_fe[i/2], frame_d[i/2]);
        end
      end else begin
        if ({data_valid_out, line_end, frame_end, data_out} !== {3'b000, frame_d[i/2]}) begin
          err_cnt++;
          $display("FAIL gaps_hold[%0d]: got dvo=%b le=%b fe=%b d=%0d want 0 0 0 %0d", i,
                   data_valid_out, line_end, frame_end, data_out, frame_d[i/2]);
        end
      end
    end
  endtask

  task automatic test_resync;
    logic [9:0] exp_d [11] = '{10'd200, 10'd100, 10'd200, 10'd200, 10'd100, 10'd200, 10'd100,
                               10'd300, 10'd200, 10'd300, 10'd200};
    logic [10:0] exp_le = 11'b10001000000;
    logic [10:0] exp_fe = 11'b10000000000;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, (i == 0) || (i == 3));
      cmp_cnt++;
      if ({data_valid_out, line_end, frame_end, data_out} !== {1'b1, exp_le[i], exp_fe[i], exp_d[i]}) begin
        err_cnt++;
        $display("FAIL resync[%0d]: got dvo=%b le=%b fe=%b d=%0d want 1 %b %b %0d", i,
                 data_valid_out, line_end, frame_end, data_out, exp_le[i], exp_fe[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0);
    end
    @(negedge clk);
    data_valid = 1'b0;
    sof        = 1'b0;
    aclr       = 1'b0;
    #1;
    cmp_cnt++;
    if ({data_valid_out, line_end, frame_end, data_out} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_async: got dvo=%b le=%b fe=%b d=%0d want all 0", data_valid_out, line_end, frame_end, data_out);
    end
    @(posedge clk);
    #1;
    cmp_cnt++;
    if ({data_valid_out, line_end, frame_end, data_out} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_hold: got dvo=%b le=%b fe=%b d=%0d want all 0", data_valid_out, line_end, frame_end, data_out);
    end
    @(negedge clk);
    aclr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      cmp_cnt++;
      if ({data_valid_out, line_end, frame_end, data_out} !== {1'b1, frame_le[i], frame_fe[i], frame_d[i]}) begin
        err_cnt++;
        $display("FAIL reset_mid[%0d]: got dvo=%b le=%b fe=%b d=%0d want 1 %b %b %0d", i,
                 data_valid_out, line_end, frame_end, data_out, frame_le[i], frame_fe[i], frame_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0);
      cmp_cnt++;
      if ({data_valid_out, line_end, frame_end, data_out} !== {1'b1, frame_le[i%8], frame_fe[i%8], frame_d[i%8]}) begin
        err_cnt++;
        $display("FAIL b2b[%0d]: got dvo=%b le=%b fe=%b d=%0d want 1 %b %b %0d", i,
                 data_valid_out, line_end, frame_end, data_out, frame_le[i%8], frame_fe[i%8], frame_d[i%8]);
      end
    end
  endtask

`ifdef RGB2RAW_PATTERN_EN
  task automatic test_pattern;
    // Row 0 emits G then R per bar pair; hand-derived from bars 0..7 at 2 pixels each.
    logic [9:0] exp_d [16] = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h000,
                               10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    pattern_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0);
      cmp_cnt++;
      if ({p_dvo, p_le, p_fe, p_data} !== {1'b1, i == 15, 1'b0, exp_d[i]}) begin
        err_cnt++;
        $display("FAIL pattern[%0d]: got dvo=%b le=%b fe=%b d=%h want 1 %b 0 %h", i,
                 p_dvo, p_le, p_fe, p_data, i == 15, exp_d[i]);
      end
    end
    pattern_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_resync();
    test_reset_mid();
    test_back_to_back();
`ifdef RGB2RAW_PATTERN_EN
    test_pattern();
`endif
    drive(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
